// File: rtl/icache_controller.sv
// icache_controller: tag/valid/LRU bookkeeping and fill sequencing for a
// 2-way set-associative instruction cache with 2 sets of 8-word lines.
// A miss stalls the sequencer while the line streams in from ROM.
module icache_controller #(
  parameter int TAG_W    = 4,
  parameter int LINE_W   = 1,
  parameter int OFFSET_W = 3,
  parameter int CNT_W    = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [TAG_W+LINE_W+OFFSET_W-1:0]  pc,
  input  logic                              fetch_en,
  input  logic                              flush,
  output logic                              hold_out,
  output logic [TAG_W+LINE_W+OFFSET_W-1:0]  rom_address,
  output logic [LINE_W-1:0]                 cache_rdline,
  output logic [OFFSET_W-1:0]               cache_rdoffset,
  output logic                              cache_rdentry,
  output logic                              cache_wren,
  output logic [LINE_W-1:0]                 cache_wrline,
  output logic [OFFSET_W-1:0]               cache_wroffset,
  output logic                              cache_wrentry,
  output logic [CNT_W-1:0]                  hit_count,
  output logic [CNT_W-1:0]                  miss_count
);

  localparam int NUM_SETS = 1 << LINE_W;
  localparam int ADDR_W   = TAG_W + LINE_W + OFFSET_W;

  typedef enum logic {
    S_IDLE,
    S_FILL
  } state_t;

  state_t                r_state;
  state_t                w_nextState;

  logic [TAG_W-1:0]      r_tag   [NUM_SETS][2];
  logic [1:0]            r_valid [NUM_SETS];
  logic [NUM_SETS-1:0]   r_lru;

  logic [TAG_W-1:0]      r_fillTag;
  logic [LINE_W-1:0]     r_fillSet;
  logic                  r_victim;
  logic [OFFSET_W-1:0]   r_k;
  logic                  r_flushPend;

  logic [CNT_W-1:0]      r_hitCount;
  logic [CNT_W-1:0]      r_missCount;

  logic [TAG_W-1:0]      w_pcTag;
  logic [LINE_W-1:0]     w_pcSet;
  logic [OFFSET_W-1:0]   w_pcOff;
  logic                  w_hit0;
  logic                  w_hit1;
  logic                  w_hit;
  logic                  w_victim;
  logic                  w_lookup;
  logic                  w_hitEvt;
  logic                  w_missEvt;
  logic                  w_lastWord;
  logic                  w_hold;

  assign w_pcTag    = pc[ADDR_W-1 -: TAG_W];
  assign w_pcSet    = pc[OFFSET_W +: LINE_W];
  assign w_pcOff    = pc[OFFSET_W-1:0];

  // Only one way can match because a fill always reuses a way holding a different tag.
  assign w_hit0     = r_valid[w_pcSet][0] && (r_tag[w_pcSet][0] == w_pcTag);
  assign w_hit1     = r_valid[w_pcSet][1] && (r_tag[w_pcSet][1] == w_pcTag);
  assign w_hit      = w_hit0 || w_hit1;

  // Empty ways are filled first (way0 before way1); otherwise the LRU way is evicted.
  assign w_victim   = !r_valid[w_pcSet][0] ? 1'b0 :
                      !r_valid[w_pcSet][1] ? 1'b1 : r_lru[w_pcSet];

  assign w_lookup   = (r_state == S_IDLE) && fetch_en;
  assign w_hitEvt   = w_lookup && w_hit;
  assign w_missEvt  = w_lookup && !w_hit;
  assign w_lastWord = (r_state == S_FILL) && (r_k == {OFFSET_W{1'b1}});

  assign cache_rdline   = w_pcSet;
  assign cache_rdoffset = w_pcOff;
  assign cache_rdentry  = w_hit1;
  assign hold_out       = w_hold && reset;
  assign hit_count      = r_hitCount;
  assign miss_count     = r_missCount;

  // Next-state and fill-port decode; stall begins in the same cycle the miss is seen.
  always_comb begin
    w_nextState    = r_state;
    w_hold         = 1'b0;
    cache_wren     = 1'b0;
    rom_address    = '0;
    cache_wrline   = '0;
    cache_wroffset = '0;
    cache_wrentry  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_missEvt) begin
          w_hold      = 1'b1;
          w_nextState = S_FILL;
        end
      end
      S_FILL: begin
        w_hold         = 1'b1;
        cache_wren     = 1'b1;
        rom_address    = {r_fillTag, r_fillSet, r_k};
        cache_wrline   = r_fillSet;
        cache_wroffset = r_k;
        cache_wrentry  = r_victim;
        if (w_lastWord) begin
          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // State register plus the line being filled, its word counter and any deferred flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_fillTag   <= '0;
      r_fillSet   <= '0;
      r_victim    <= 1'b0;
      r_k         <= '0;
      r_flushPend <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_missEvt) begin
        r_fillTag <= w_pcTag;
        r_fillSet <= w_pcSet;
        r_victim  <= w_victim;
        r_k       <= '0;
      end else if (r_state == S_FILL) begin
        r_k <= r_k + 1'b1;
      end
      if (w_lastWord) begin
        r_flushPend <= 1'b0;
      end else if ((r_state == S_FILL) && flush) begin
        r_flushPend <= 1'b1;
      end
    end
  end

  // Tag, valid and LRU updates; the victim is invalidated as soon as its fill starts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        r_valid[s]  <= 2'b00;
        r_tag[s][0] <= '0;
        r_tag[s][1] <= '0;
      end
      r_lru <= '0;
    end else begin
      if (w_missEvt) begin
        r_valid[w_pcSet][w_victim] <= 1'b0;
      end
      if (w_hitEvt && !flush) begin
        r_lru[w_pcSet] <= w_hit0;
      end
      if ((r_state == S_IDLE) && flush) begin
        for (int s = 0; s < NUM_SETS; s++) begin
          r_valid[s] <= 2'b00;
        end
        r_lru <= '0;
      end
      if (w_lastWord) begin
        if (r_flushPend || flush) begin
          for (int s = 0; s < NUM_SETS; s++) begin
            r_valid[s] <= 2'b00;
          end
          r_lru <= '0;
        end else begin
          r_tag[r_fillSet][r_victim]   <= r_fillTag;
          r_valid[r_fillSet][r_victim] <= 1'b1;
          r_lru[r_fillSet]             <= ~r_victim;
        end
      end
    end
  end

  // Saturating hit/miss statistics, counted only for lookups made in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hitCount  <= '0;
      r_missCount <= '0;
    end else begin
      if (w_hitEvt && (r_hitCount != {CNT_W{1'b1}})) begin
        r_hitCount <= r_hitCount + 1'b1;
      end
      if (w_missEvt && (r_missCount != {CNT_W{1'b1}})) begin
        r_missCount <= r_missCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_controller.sv
// Testbench for icache_controller: a per-cycle vector table covering fills,
// hits, LRU eviction, reset mid-fill and flush, plus a hit-counter
// saturation sequence.
module tb_icache_controller;

  logic       clk;
  logic       reset;
  logic [7:0] pc;
  logic       fetch_en;
  logic       flush;
  logic       hold_out;
  logic [7:0] rom_address;
  logic       cache_rdline;
  logic [2:0] cache_rdoffset;
  logic       cache_rdentry;
  logic       cache_wren;
  logic       cache_wrline;
  logic [2:0] cache_wroffset;
  logic       cache_wrentry;
  logic [7:0] hit_count;
  logic [7:0] miss_count;

  int passCount  = 0;
  int checkCount = 0;

  typedef struct {
    logic       rst;
    logic [7:0] pc;
    logic       fe;
    logic       fl;
    logic       hold;
    logic       wren;
    logic [7:0] rom;
    logic [2:0] wroff;
    logic       wrent;
    logic       wrline;
    logic       rdent;
    logic [7:0] hits;
    logic [7:0] misses;
  } vec_t;

  vec_t vecs[$];

  icache_controller dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .fetch_en       (fetch_en),
    .flush          (flush),
    .hold_out       (hold_out),
    .rom_address    (rom_address),
    .cache_rdline   (cache_rdline),
    .cache_rdoffset (cache_rdoffset),
    .cache_rdentry  (cache_rdentry),
    .cache_wren     (cache_wren),
    .cache_wrline   (cache_wrline),
    .cache_wroffset (cache_wroffset),
    .cache_wrentry  (cache_wrentry),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Single comparison with pass/fail bookkeeping
  task automatic checkOutput(input string name, input int idx,
                             input logic [7:0] act, input logic [7:0] exp);
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
    end
  endtask

  // Append one per-cycle vector
  task automatic addVec(input logic rst, input logic [7:0] a, input logic fe,
                        input logic fl, input logic hold, input logic wren,
                        input logic [7:0] rom, input logic [2:0] wroff,
                        input logic wrent, input logic wrline, input logic rdent,
                        input logic [7:0] h, input logic [7:0] m);
    vec_t v;
    v.rst = rst; v.pc = a; v.fe = fe; v.fl = fl; v.hold = hold; v.wren = wren;
    v.rom = rom; v.wroff = wroff; v.wrent = wrent; v.wrline = wrline;
    v.rdent = rdent; v.hits = h; v.misses = m;
    vecs.push_back(v);
  endtask

  // Miss-detect cycle followed by the 8 fill cycles; flushAt<0 means no flush
  task automatic addMiss(input logic [7:0] a, input logic vic,
                         input logic [7:0] h, input logic [7:0] m, input int flushAt);
    logic [7:0] base;
    logic [2:0] kk;
    base = {a[7:3], 3'b000};
    addVec(1'b1, a, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, h, m);
    for (int k = 0; k < 8; k++) begin
      kk = k[2:0];
      addVec(1'b1, a, 1'b1, (k == flushAt), 1'b1, 1'b1, base | {5'b0, kk}, kk,
             vic, a[3], 1'b0, h, m + 8'd1);
    end
  endtask

  // Single hitting lookup
  task automatic addHit(input logic [7:0] a, input logic ent,
                        input logic [7:0] h, input logic [7:0] m);
    addVec(1'b1, a, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, ent, h, m);
  endtask

  // Drive each vector just after the rising edge and compare at the falling edge
  task automatic applyStimulus();
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      reset    = vecs[i].rst;
      pc       = vecs[i].pc;
      fetch_en = vecs[i].fe;
      flush    = vecs[i].fl;
      @(negedge clk);
      checkOutput("hold_out",      i, 8'(hold_out),      8'(vecs[i].hold));
      checkOutput("cache_wren",    i, 8'(cache_wren),    8'(vecs[i].wren));
      checkOutput("rom_address",   i, rom_address,       vecs[i].rom);
      checkOutput("cache_rdentry", i, 8'(cache_rdentry), 8'(vecs[i].rdent));
      checkOutput("cache_rdoffset", i, 8'(cache_rdoffset), 8'(vecs[i].pc[2:0]));
      checkOutput("hit_count",     i, hit_count,         vecs[i].hits);
      checkOutput("miss_count",    i, miss_count,        vecs[i].misses);
      if (vecs[i].wren) begin
        checkOutput("cache_wroffset", i, 8'(cache_wroffset), 8'(vecs[i].wroff));
        checkOutput("cache_wrentry",  i, 8'(cache_wrentry),  8'(vecs[i].wrent));
        checkOutput("cache_wrline",   i, 8'(cache_wrline),   8'(vecs[i].wrline));
      end
    end
  endtask

  initial begin
    clk      = 1'b0;
    reset    = 1'b0;
    pc       = 8'h00;
    fetch_en = 1'b0;
    flush    = 1'b0;

    // Reset state
    addVec(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    addVec(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);

    // Cold miss on 00 into way0, then sequential hits through the line
    addMiss(8'h00, 1'b0, 8'd0, 8'd0, -1);
    addHit(8'h00, 1'b0, 8'd0, 8'd1);
    for (int i = 1; i < 8; i++) begin
      addHit(8'(i), 1'b0, 8'(i), 8'd1);
    end
    addVec(1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 8'd8, 8'd1);

    // Conflict in set0: 10 goes to empty way1, 00 touched, 20 evicts 10, 10 evicts 00
    addMiss(8'h10, 1'b1, 8'd8, 8'd1, -1);
    addHit(8'h10, 1'b1, 8'd8, 8'd2);
    addHit(8'h00, 1'b0, 8'd9, 8'd2);
    addMiss(8'h20, 1'b1, 8'd10, 8'd2, -1);
    addHit(8'h20, 1'b1, 8'd10, 8'd3);
    addMiss(8'h10, 1'b0, 8'd11, 8'd3, -1);
    addHit(8'h10, 1'b0, 8'd11, 8'd4);

    // Miss on 08, reset asserted when the fill reaches k=4
    addVec(1'b1, 8'h08, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 8'd11 + 8'd1, 8'd4);
    for (int k = 0; k < 4; k++) begin
      addVec(1'b1, 8'h08, 1'b1, 1'b0, 1'b1, 1'b1, 8'h08 + 8'(k), 3'(k), 1'b0, 1'b1,
             1'b0, 8'd12, 8'd5);
    end
    addVec(1'b0, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    addMiss(8'h08, 1'b0, 8'd0, 8'd0, -1);
    addHit(8'h08, 1'b0, 8'd0, 8'd1);
    addMiss(8'h00, 1'b0, 8'd1, 8'd1, -1);
    addHit(8'h00, 1'b0, 8'd1, 8'd2);

    // Flush in IDLE alongside a hit, then a flush during the refill
    addVec(1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd2);
    addMiss(8'h00, 1'b0, 8'd3, 8'd2, 3);
    addMiss(8'h00, 1'b0, 8'd3, 8'd3, -1);
    addHit(8'h00, 1'b0, 8'd3, 8'd4);
    addMiss(8'h08, 1'b0, 8'd4, 8'd4, -1);
    addHit(8'h08, 1'b0, 8'd4, 8'd5);

    applyStimulus();

    // Hit counter saturation: keep fetching the resident line 08
    repeat (300) @(posedge clk);
    @(negedge clk);
    checkOutput("hit_count_sat",  -1, hit_count,      8'hFF);
    checkOutput("miss_count_sat", -1, miss_count,     8'd5);
    checkOutput("hold_sat",       -1, 8'(hold_out),   8'd0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("hit_count_hold", -1, hit_count,      8'hFF);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
